// File: rtl/sl_pkg.sv
// Shared definitions for the SL serial-line transmitter and receiver:
// config field positions, reset config, BQ legality, FSM states, frame builder.
package sl_pkg;

  localparam int          CFG_PINV  = 0;
  localparam int          CFG_BQL   = 1;
  localparam int          CFG_BQH   = 6;
  localparam logic [15:0] CFG_RESET = 16'h0010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_STOP,
    ST_IFG
  } sl_state_e;

  function automatic logic bq_legal(input logic [5:0] bq);
    return !bq[0] && (bq >= 6'd8) && (bq <= 6'd32);
  endfunction

  // Data bits below BQ, odd parity at position BQ (optionally inverted).
  function automatic logic [32:0] sl_frame(input logic [31:0] data,
                                           input logic [5:0]  bq,
                                           input logic        pinv);
    logic [31:0] d;
    logic [32:0] frame;
    d         = data & 32'((33'd1 << bq) - 33'd1);
    frame     = {1'b0, d};
    frame[bq] = ~^d ^ pinv;
    return frame;
  endfunction

endpackage

// File: rtl/sl_transmitter.sv
// SL word transmitter: serialises a handshaken word LSB-first onto the
// ones/zeroes line pair as BQ data bits, odd parity and a stop bit.
//
// state    | meaning
// ST_IDLE  | tx_ready high, waiting for a word
// ST_PULSE | current bit's low pulse on its line
// ST_GAP   | both lines high between bits
// ST_STOP  | stop bit, both lines low
// ST_IFG   | inter-frame idle before tx_ready returns
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int CONFIG_WIDTH = 16,
  parameter int PULSE_LEN    = 16,
  parameter int GAP_LEN      = 16,
  parameter int IFG_LEN      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CONFIG_WIDTH-1:0] wr_config_w,
  input  logic                    wr_enable,
  output logic [CONFIG_WIDTH-1:0] r_config_w,
  input  logic [31:0]             tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    serial_line_ones,
  output logic                    serial_line_zeroes,
  output logic                    busy,
  output logic                    tx_done
);

  sl_state_e               state;
  logic [CONFIG_WIDTH-1:0] cfg_q;
  logic [5:0]              cyc_cnt;
  logic [5:0]              bit_cnt;
  logic [5:0]              word_bq;
  logic [32:0]             shreg;
  logic                    last_q;

  logic       cfg_wr_ok;
  logic       handshake;
  logic [5:0] bq_eff;
  logic       pinv_eff;

  assign cfg_wr_ok = wr_enable && (state == ST_IDLE) && bq_legal(wr_config_w[CFG_BQH:CFG_BQL]);
  assign handshake = tx_valid && tx_ready;

  // A write landing on the handshake edge already governs that word.
  assign bq_eff   = cfg_wr_ok ? wr_config_w[CFG_BQH:CFG_BQL] : cfg_q[CFG_BQH:CFG_BQL];
  assign pinv_eff = cfg_wr_ok ? wr_config_w[CFG_PINV] : cfg_q[CFG_PINV];

  assign r_config_w = cfg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= CONFIG_WIDTH'(CFG_RESET);
    end else if (cfg_wr_ok) begin
      cfg_q <= wr_config_w;
    end
  end

  // Outputs are registered from the current state, so lines, ready and done
  // all trail the state register by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      cyc_cnt            <= '0;
      bit_cnt            <= '0;
      word_bq            <= '0;
      shreg              <= '0;
      last_q             <= 1'b0;
      tx_ready           <= 1'b1;
      busy               <= 1'b0;
      tx_done            <= 1'b0;
      serial_line_ones   <= 1'b1;
      serial_line_zeroes <= 1'b1;
    end else begin
      serial_line_ones   <= !((state == ST_PULSE && shreg[0]) || state == ST_STOP);
      serial_line_zeroes <= !((state == ST_PULSE && !shreg[0]) || state == ST_STOP);
      tx_ready           <= (state == ST_IDLE) && !handshake;
      busy               <= (state != ST_IDLE) || handshake;
      tx_done            <= (state == ST_IDLE) && !tx_ready;

      cyc_cnt <= (cyc_cnt == 6'h3f) ? cyc_cnt : cyc_cnt + 6'd1;

      case (state)
        ST_IDLE: begin
          if (handshake) begin
            shreg   <= sl_frame(tx_data, bq_eff, pinv_eff);
            word_bq <= bq_eff;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            last_q  <= 1'b0;
            state   <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (cyc_cnt == 6'(PULSE_LEN - 1)) begin
            cyc_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_STOP: begin
          if (cyc_cnt == 6'(PULSE_LEN - 1)) begin
            cyc_cnt <= '0;
            last_q  <= 1'b1;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cyc_cnt == 6'(GAP_LEN - 1)) begin
            cyc_cnt <= '0;
            if (last_q) begin
              state <= ST_IFG;
            end else if (bit_cnt < word_bq) begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 6'd1;
              state   <= ST_PULSE;
            end else begin
              state <= ST_STOP;
            end
          end
        end
        ST_IFG: begin
          if (cyc_cnt == 6'(IFG_LEN - 1)) begin
            cyc_cnt <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter: decodes the line pair itself and checks
// bit values, parity, pulse widths, latency, tx_done timing and config rules.
module tb_sl_transmitter;

  localparam int PULSE = 16;
  localparam int GAP   = 16;
  localparam int IFG   = 32;

  logic        clk;
  logic        rst_n;
  logic [15:0] wr_config_w;
  logic        wr_enable;
  logic [15:0] r_config_w;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        serial_line_ones;
  logic        serial_line_zeroes;
  logic        busy;
  logic        tx_done;

  int vectors;
  int miscompares;

  sl_transmitter #(
    .CONFIG_WIDTH(16),
    .PULSE_LEN(PULSE),
    .GAP_LEN(GAP),
    .IFG_LEN(IFG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_config_w(wr_config_w),
    .wr_enable(wr_enable),
    .r_config_w(r_config_w),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .serial_line_ones(serial_line_ones),
    .serial_line_zeroes(serial_line_zeroes),
    .busy(busy),
    .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input string tag, input logic [15:0] val, input logic [15:0] exp);
    @(negedge clk);
    wr_config_w = val;
    wr_enable   = 1'b1;
    @(posedge clk);
    #1;
    wr_enable = 1'b0;
    check_eq(tag, {48'd0, r_config_w}, {48'd0, exp});
  endtask

  // Sends one word and decodes the line pair. wr_at: 0 = config write on the
  // handshake edge, n>0 = write n cycles later, <0 = none.
  task automatic send_word(input string tag, input logic [31:0] data, input int bq,
                           input logic pinv, input int wr_at, input logic [15:0] wr_val);
    int          first_fall, done_at, nbits, nstop, seg_len, seg_kind, bad, ones, k;
    logic        in_seg, par;
    logic [31:0] m;
    logic [32:0] rx;
    first_fall = -1; done_at = -1; nbits = 0; nstop = 0; seg_len = 0;
    seg_kind = 0; bad = 0; ones = 0; in_seg = 1'b0; rx = '0;
    m = (bq >= 32) ? 32'hffff_ffff : ((32'd1 << bq) - 32'd1);
    for (int i = 0; i < 32; i++) if (m[i] && data[i]) ones++;
    par = ((ones % 2) == 0) ^ pinv;

    @(negedge clk);
    check_eq({tag, ".ready_before"}, {63'd0, tx_ready}, 64'd1);
    tx_data  = data;
    tx_valid = 1'b1;
    if (wr_at == 0) begin
      wr_enable   = 1'b1;
      wr_config_w = wr_val;
    end
    @(posedge clk);
    #1;
    tx_valid  = 1'b0;
    wr_enable = 1'b0;
    tx_data   = 32'hffff_ffff;
    for (int n = 1; n <= 1500 && done_at < 0; n++) begin
      @(posedge clk);
      #1;
      wr_enable = 1'b0;
      if (n == 1) begin
        check_eq({tag, ".busy_n1"}, {63'd0, busy}, 64'd1);
        check_eq({tag, ".ready_n1"}, {63'd0, tx_ready}, 64'd0);
      end
      if (!serial_line_ones || !serial_line_zeroes) begin
        if (first_fall < 0) first_fall = n;
        k = (!serial_line_ones && !serial_line_zeroes) ? 2 : (!serial_line_ones ? 1 : 0);
        if (!in_seg) begin
          in_seg = 1'b1; seg_kind = k; seg_len = 1;
        end else begin
          seg_len++;
          if (k != seg_kind) bad++;
        end
      end else if (in_seg) begin
        in_seg = 1'b0;
        if (seg_len != PULSE) bad++;
        if (seg_kind == 2) nstop++;
        else begin
          if (nbits < 33) rx[nbits] = (seg_kind == 1);
          nbits++;
        end
      end
      if (tx_done) begin
        done_at = n;
        check_eq({tag, ".ready_at_done"}, {63'd0, tx_ready}, 64'd1);
      end
      if (n == wr_at) begin
        wr_enable   = 1'b1;
        wr_config_w = wr_val;
      end
    end
    check_eq({tag, ".first_fall"}, 64'(first_fall), 64'd1);
    check_eq({tag, ".done_cycle"}, 64'(done_at), 64'(1 + (bq + 2) * (PULSE + GAP) + IFG));
    check_eq({tag, ".nbits"}, 64'(nbits), 64'(bq + 1));
    check_eq({tag, ".nstop"}, 64'(nstop), 64'd1);
    check_eq({tag, ".pulse_shape"}, 64'(bad), 64'd0);
    check_eq({tag, ".data"}, {32'd0, rx[31:0] & m}, {32'd0, data & m});
    check_eq({tag, ".parity"}, {63'd0, rx[bq]}, {63'd0, par});
    @(posedge clk);
    #1;
    check_eq({tag, ".done_1cyc"}, {63'd0, tx_done}, 64'd0);
  endtask

  initial begin
    int dones;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    wr_config_w = '0;
    wr_enable   = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    #23;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check_eq("rst.ones", {63'd0, serial_line_ones}, 64'd1);
    check_eq("rst.zeroes", {63'd0, serial_line_zeroes}, 64'd1);
    check_eq("rst.ready", {63'd0, tx_ready}, 64'd1);
    check_eq("rst.busy", {63'd0, busy}, 64'd0);
    check_eq("rst.done", {63'd0, tx_done}, 64'd0);
    check_eq("rst.config", {48'd0, r_config_w}, 64'h0010);

    cfg_write("cfg.bq7", 16'h000e, 16'h0010);
    cfg_write("cfg.bq34", 16'h0044, 16'h0010);

    send_word("a5", 32'h0000_00a5, 8, 1'b0, -1, 16'h0);

    // Config write on the handshake edge: word uses BQ=32.
    send_word("deadbeef", 32'hdead_beef, 32, 1'b0, 0, 16'h0040);
    check_eq("cfg.after_coincident", {48'd0, r_config_w}, 64'h0040);

    cfg_write("cfg.bq16", 16'h0020, 16'h0020);
    send_word("w1234", 32'h0000_1234, 16, 1'b0, 50, 16'h0011);
    check_eq("cfg.busy_write", {48'd0, r_config_w}, 64'h0020);

    cfg_write("cfg.pinv", 16'h0011, 16'h0011);
    send_word("pinv3c", 32'h0000_003c, 8, 1'b1, -1, 16'h0);

    // Reset mid-pulse: lines must rise without waiting for a clock edge.
    @(negedge clk);
    tx_data  = 32'h0000_0081;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check_eq("mid.ones_low", {63'd0, serial_line_ones}, 64'd0);
    rst_n = 1'b0;
    #1;
    check_eq("mid.ones_async", {63'd0, serial_line_ones}, 64'd1);
    check_eq("mid.zeroes_async", {63'd0, serial_line_zeroes}, 64'd1);
    check_eq("mid.ready_async", {63'd0, tx_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (tx_done) dones++;
    end
    check_eq("mid.no_done", 64'(dones), 64'd0);
    check_eq("mid.config_reset", {48'd0, r_config_w}, 64'h0010);
    send_word("after_rst", 32'h0000_005a, 8, 1'b0, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
